// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, bit-timing constants and the majority voter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int unsigned UART_OSR        = 16;
    localparam int unsigned UART_SAMPLE_LO  = 7;
    localparam int unsigned UART_SAMPLE_MID = 8;
    localparam int unsigned UART_SAMPLE_HI  = 9;
    localparam int unsigned UART_DATA_BITS  = 8;

    // 2-of-3 vote over the three mid-bit samples.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// The head word, empty and full are all registered.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        // The incoming word becomes the head when it lands in the slot the read pointer moves to.
        head_d  = (do_push && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign rd_data = head_q;
    assign empty   = empty_q;
    assign full    = full_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 16x oversampled 8N1 decoder with 2-of-3 voting,
// feeding a FWFT receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned OSR   = UART_OSR
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       clk_uart16,
    input  logic       RXD,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int unsigned TW = $clog2(OSR);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);

    logic                      sync1_q, rxs_q;
    rx_state_t                 state_q, state_d;
    logic [TW-1:0]             tcnt_q, tcnt_d;
    logic [BW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]                samp_q, samp_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      rx_busy_q, rx_busy_d;
    logic                      fifo_push;
    logic                      bit_end, bit_maj, stop_maj;

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        samp_d      = samp_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        fifo_push   = 1'b0;

        bit_end  = clk_uart16 && (tcnt_q == TW'(OSR - 1));
        bit_maj  = maj3(samp_q);
        // The stop decision happens on the third sample's tick, so vote with the live value.
        stop_maj = maj3({rxs_q, samp_q[1:0]});

        if ((state_q != IDLE) && clk_uart16) begin
            tcnt_d = (tcnt_q == TW'(OSR - 1)) ? '0 : tcnt_q + TW'(1);
            if (tcnt_q == TW'(UART_SAMPLE_LO))  samp_d[0] = rxs_q;
            if (tcnt_q == TW'(UART_SAMPLE_MID)) samp_d[1] = rxs_q;
            if (tcnt_q == TW'(UART_SAMPLE_HI))  samp_d[2] = rxs_q;
        end

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    tcnt_d  = '0;
                    samp_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = bit_maj ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d[bit_idx_q] = bit_maj;
                    if (bit_idx_q == BW'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (clk_uart16 && (tcnt_q == TW'(UART_SAMPLE_HI))) begin
                    state_d = IDLE;
                    if (!stop_maj) begin
                        frame_err_d = 1'b1;
                    end else if (rx_full && !rd_en) begin
                        overrun_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            samp_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            sync1_q     <= RXD;
            rxs_q       <= sync1_q;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            samp_q      <= samp_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .RST     (RST),
        .push    (fifo_push),
        .wr_data (shreg_q),
        .pop     (rd_en),
        .rd_data (rx_data),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand sequences for
// glitch, fill/overrun, push+pop while full and reset mid-frame.
module tb_uart_rx;

    localparam int DEPTH  = 16;
    localparam int BITCLK = 64;   // 16 ticks x 4 clk per tick
    localparam int FRAME  = 640;  // 10 bits
    localparam int DECIDE = 616;  // start edge to STOP decision: 9 bits + 10 ticks

    logic       clk = 1'b0;
    logic       RST;
    logic       clk_uart16;
    logic       RXD;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rx_empty, rx_full, frame_err, overrun, rx_busy;

    uart_rx #(.DEPTH(DEPTH), .OSR(16)) dut (
        .clk        (clk),
        .RST        (RST),
        .clk_uart16 (clk_uart16),
        .RXD        (RXD),
        .rd_en      (rd_en),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // tick strobe one clk wide every 4 clk
    initial begin
        clk_uart16 = 1'b0;
        forever begin
            @(negedge clk);
            clk_uart16 = ((cyc + 1) % 4 == 0);
        end
    end

    int   fe_cycles = 0;
    int   ov_cycles = 0;
    int   full_low  = 0;
    int   fall_cyc  = -1;
    logic prev_empty = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) fe_cycles++;
            if (overrun === 1'b1) ov_cycles++;
            if (rx_full !== 1'b1) full_low++;
            if (rx_empty === 1'b0 && prev_empty === 1'b1) fall_cyc = cyc;
            prev_empty = rx_empty;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp);
        checks++;
        if (act < exp - 1 || act > exp + 1) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/-1", name, act, exp);
        end
    endtask

    // Drives one 8N1 frame aligned to a tick; optionally pops at the decision
    // cycle or pulses RST at a given offset and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit pop_at_decide,
                              input int abort_rel, output int p0);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        while (((cyc + 1) % 4) != 0) @(negedge clk);
        p0 = cyc + 1;
        for (int rel = 0; rel < FRAME; rel++) begin
            if (abort_rel > 0 && rel == abort_rel) begin
                RST = 1'b1;
                RXD = 1'b1;
                rd_en = 1'b0;
                @(negedge clk);
                RST = 1'b0;
                return;
            end
            RXD   = bits[rel / BITCLK];
            rd_en = pop_at_decide && (rel == DECIDE);
            @(negedge clk);
        end
        RXD   = 1'b1;
        rd_en = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, 32'(rx_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        int         exp_fe;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input string tag);
        int p0;
        fe_cycles = 0;
        ov_cycles = 0;
        fall_cyc  = -1;
        send_frame(v.data, v.stop, 1'b0, 0, p0);
        repeat (80) @(negedge clk);
        chk({tag, " frame_err"}, 32'(fe_cycles), 32'(v.exp_fe));
        chk({tag, " overrun"}, 32'(ov_cycles), 32'd0);
        chk({tag, " busy"}, 32'(rx_busy), 32'd0);
        chk({tag, " empty"}, 32'(rx_empty), 32'(!v.exp_push));
        if (v.exp_push) begin
            chk_tol({tag, " empty_fall"}, fall_cyc, p0 + DECIDE);
            pop_chk({tag, " data"}, v.data);
            chk({tag, " empty_after_pop"}, 32'(rx_empty), 32'd1);
        end
    endtask

    initial begin
        int p0;
        vecs[0] = '{data: 8'h3C, stop: 1'b1, exp_push: 1'b1, exp_fe: 0};
        vecs[1] = '{data: 8'hA5, stop: 1'b1, exp_push: 1'b1, exp_fe: 0};
        vecs[2] = '{data: 8'h55, stop: 1'b0, exp_push: 1'b0, exp_fe: 1};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_push: 1'b1, exp_fe: 0};
        vecs[4] = '{data: 8'h00, stop: 1'b1, exp_push: 1'b1, exp_fe: 0};

        RST = 1'b1;
        RXD = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        chk("reset rx_empty", 32'(rx_empty), 32'd1);
        chk("reset rx_full", 32'(rx_full), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        chk("reset rx_busy", 32'(rx_busy), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
        repeat (8) @(negedge clk);

        // glitch: RXD low for 3 ticks is a false start
        fe_cycles = 0;
        ov_cycles = 0;
        while (((cyc + 1) % 4) != 0) @(negedge clk);
        RXD = 1'b0;
        repeat (12) @(negedge clk);
        RXD = 1'b1;
        repeat (80) @(negedge clk);
        chk("glitch busy", 32'(rx_busy), 32'd0);
        chk("glitch empty", 32'(rx_empty), 32'd1);
        chk("glitch frame_err", 32'(fe_cycles), 32'd0);
        chk("glitch overrun", 32'(ov_cycles), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // 17 back-to-back frames with no reads
        fe_cycles = 0;
        ov_cycles = 0;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 0, p0);
            if (i == 14) chk("fill15 full", 32'(rx_full), 32'd0);
            if (i == 15) chk("fill16 full", 32'(rx_full), 32'd1);
        end
        repeat (4) @(negedge clk);
        chk("fill overrun", 32'(ov_cycles), 32'd1);
        chk("fill frame_err", 32'(fe_cycles), 32'd0);
        chk("fill head", 32'(rx_data), 32'h00);
        for (int i = 0; i < 16; i++) begin
            pop_chk($sformatf("drain%0d", i), 8'(i));
        end
        chk("drain empty", 32'(rx_empty), 32'd1);
        chk("drain full", 32'(rx_full), 32'd0);

        // push and pop in the same cycle while full
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(8'h20 + i), 1'b1, 1'b0, 0, p0);
        end
        chk("refill full", 32'(rx_full), 32'd1);
        full_low  = 0;
        ov_cycles = 0;
        send_frame(8'h30, 1'b1, 1'b1, 0, p0);
        repeat (4) @(negedge clk);
        chk("pushpop full held", 32'(full_low), 32'd0);
        chk("pushpop overrun", 32'(ov_cycles), 32'd0);
        for (int i = 0; i < 15; i++) begin
            pop_chk($sformatf("pushpop pop%0d", i), 8'(8'h21 + i));
        end
        pop_chk("pushpop last", 8'h30);
        chk("pushpop empty", 32'(rx_empty), 32'd1);

        // reset mid-DATA discards the partial frame and empties the FIFO
        send_frame(8'h42, 1'b1, 1'b0, 0, p0);
        repeat (8) @(negedge clk);
        chk("pre-reset empty", 32'(rx_empty), 32'd0);
        fe_cycles = 0;
        ov_cycles = 0;
        send_frame(8'hF0, 1'b1, 1'b0, 150, p0);
        chk("midreset empty", 32'(rx_empty), 32'd1);
        chk("midreset data", 32'(rx_data), 32'd0);
        chk("midreset busy", 32'(rx_busy), 32'd0);
        repeat (8) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 0, p0);
        repeat (80) @(negedge clk);
        chk("post-reset frame_err", 32'(fe_cycles), 32'd0);
        chk("post-reset overrun", 32'(ov_cycles), 32'd0);
        pop_chk("post-reset data", 8'h81);
        chk("post-reset empty", 32'(rx_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
